serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-multiplexes a single `fullAdder` cell across a WIDTH-bit operation, one bit per clock, LSB first. It accepts operands over a valid/ready handshake and sequences the shift registers and carry flop. It returns the sum plus ARM-style N/Z/C/V flags over a second valid/ready handshake. It is the area-minimal ALU adder option for the 16-bit CPU core and serves as a low-rate arithmetic helper beside the AES accelerator.

---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/serial_add_ctrl_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM states, the N/Z/C/V flag bundle
// (also used by the CPU core's CPSR logic), and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell; the serial adder time-multiplexes a single instance.
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one result bit per clock, LSB first,
// through a single fullAdder, returning the sum plus N/Z/C/V flags.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here decode from state and reset only, never from
  // the partner's valid/ready, and a raised valid is held until the transfer.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic             fa_s, fa_cout;

  fullAdder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB; V compares it with the carry out.
          cmsb_d    = carry_q;
          flags_d.n = fa_s;
          flags_d.z = (sum_d == '0);
          flags_d.c = fa_cout;
          flags_d.v = carry_q ^ fa_cout;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready  = !reset && (state_q == IDLE);
  assign result_valid = !reset && (state_q == DONE);
  assign sum          = sum_q;
  assign flag_n       = flags_q.n;
  assign flag_z       = flags_q.z;
  assign flag_c       = flags_q.c;
  assign flag_v       = flags_q.v;
  assign state_o      = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=16: arithmetic/flag vectors,
// latency, input isolation, result backpressure and mid-operation reset.
module tb_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum;
  logic         flag_n, flag_z, flag_c, flag_v;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .sub          (sub),
    .cin          (cin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Present one operation at a negedge, let it be accepted on the next
  // posedge, then scramble the operands so later edges must ignore them.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tcin);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a   = W'($urandom_range(0, 65535));
    b   = W'($urandom_range(0, 65535));
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
  endtask

  // Count edges after acceptance until result_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (result_valid) break;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_handshake: start_ready=%b result_valid=%b required 0 0", start_ready, result_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0 || sum !== 16'h0000 ||
        {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b sum=%h nzcv=%b required 1 0 0000 0000",
               start_ready, result_valid, sum, {flag_n, flag_z, flag_c, flag_v});
    end
  endtask

  // Directed arithmetic vectors with hand-computed sums and flags.
  task automatic test_arith();
    logic [W-1:0] va [6] = '{16'h0001, 16'h7FFF, 16'h0005, 16'h0007, 16'h1234, 16'hFFFF};
    logic [W-1:0] vb [6] = '{16'hFFFF, 16'h0001, 16'h0007, 16'h0005, 16'h4321, 16'hFFFF};
    logic         vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] es [6] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0002, 16'h5556, 16'hFFFF};
    logic [3:0]   ef [6] = '{4'b0110, 4'b1001, 4'b1000, 4'b0010, 4'b0000, 4'b1010};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vs[i], vc[i]);
      wait_result(lat);
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL latency_%0d: %0d cycles required %0d", i, lat, W);
      end
      checks++;
      if (sum !== es[i]) begin
        errors++;
        $display("FAIL sum_%0d: got %h required %h", i, sum, es[i]);
      end
      checks++;
      if ({flag_n, flag_z, flag_c, flag_v} !== ef[i]) begin
        errors++;
        $display("FAIL nzcv_%0d: got %b required %b", i, {flag_n, flag_z, flag_c, flag_v}, ef[i]);
      end
      take_result();
      checks++;
      if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL release_%0d: rdy=%b vld=%b required 1 0", i, start_ready, result_valid);
      end
    end
  endtask

  // Result held for 5 cycles; a queued request is taken right after release.
  task automatic test_back_to_back();
    int lat;
    start_op(16'h2000, 16'h3000, 1'b0, 1'b0);
    wait_result(lat);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b1 || start_ready !== 1'b0 || sum !== 16'h5000 ||
          {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
        errors++;
        $display("FAIL hold_%0d: vld=%b rdy=%b sum=%h nzcv=%b required 1 0 5000 0000",
                 i, result_valid, start_ready, sum, {flag_n, flag_z, flag_c, flag_v});
      end
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: rdy=%b vld=%b required 1 0", start_ready, result_valid);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL queued_accept: start_ready=%b required 0", start_ready);
    end
    wait_result(lat);
    checks++;
    if (lat != W || sum !== 16'h0100 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL queued_result: lat=%0d sum=%h nzcv=%b required %0d 0100 0000",
               lat, sum, {flag_n, flag_z, flag_c, flag_v}, W);
    end
    take_result();
  endtask

  // Reset at bit 8 of SHIFT discards the operation; a fresh op then works.
  task automatic test_reset_mid();
    int lat;
    int seen;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_gating: rdy=%b vld=%b required 0 0", start_ready, result_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0 || sum !== 16'h0000 ||
        {flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_state: rdy=%b vld=%b sum=%h nzcv=%b required 1 0 0000 0000",
               start_ready, result_valid, sum, {flag_n, flag_z, flag_c, flag_v});
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result: %0d valid cycles required 0", seen);
    end
    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_result(lat);
    checks++;
    if (lat != W || sum !== 16'h0000 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0111) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d sum=%h nzcv=%b required %0d 0000 0111",
               lat, sum, {flag_n, flag_z, flag_c, flag_v}, W);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
